// File: rtl/ex_operand_stage.sv
// ex_operand_stage: the ID/EX register of the RV32I pipeline, directly upstream of the ALU.
// It holds one decoded instruction behind a valid/ready handshake and builds the ALU
// operands from the register file, the immediate or the PC. MEM/WB results are bypassed
// at capture. While the stage is stalled it keeps snooping the bypass buses, so a held
// operand never goes stale.
module ex_operand_stage #(
  parameter int XLEN = 32  // datapath width; the ALU is fixed at 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  // decode side
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1_addr,
  input  logic [4:0]      id_rs2_addr,
  input  logic [4:0]      id_rd_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_alu_op,
  input  logic            id_use_pc,
  input  logic            id_use_imm,
  input  logic            id_reg_write,
  // bypass buses
  input  logic            mem_fwd_valid,
  input  logic [4:0]      mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_fwd_valid,
  input  logic [4:0]      wb_fwd_rd,
  input  logic [XLEN-1:0] wb_fwd_data,
  // execute side
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [3:0]      ex_alu_op,
  output logic [XLEN-1:0] ex_store_data,
  output logic [4:0]      ex_rd_addr,
  output logic            ex_reg_write,
  output logic [XLEN-1:0] ex_pc
);

  // Result of looking one source register up on the bypass buses.
  typedef struct packed {
    logic            hit;
    logic [XLEN-1:0] data;
  } bypass_t;

  // MEM is younger than WB, so MEM wins. x0 never matches, because a producer that
  // "writes" x0 must not leak its value into a consumer.
  function automatic bypass_t bypass_lookup(
    input logic [4:0]      src,
    input logic            mem_v,
    input logic [4:0]      mem_rd,
    input logic [XLEN-1:0] mem_d,
    input logic            wb_v,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_d
  );
    bypass_t res;
    res.hit  = 1'b0;
    res.data = '0;
    if (src != 5'd0) begin
      if (mem_v && (mem_rd == src)) begin
        res.hit  = 1'b1;
        res.data = mem_d;
      end else if (wb_v && (wb_rd == src)) begin
        res.hit  = 1'b1;
        res.data = wb_d;
      end
    end
    return res;
  endfunction

  // Pipeline registers
  logic            r_valid;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [3:0]      r_alu_op;
  logic [XLEN-1:0] r_store_data;
  logic [4:0]      r_rd_addr;
  logic            r_reg_write;
  logic [XLEN-1:0] r_pc;
  // Source description kept so the stalled entry can snoop the bypass buses
  logic [4:0]      r_rs1_addr;
  logic [4:0]      r_rs2_addr;
  logic            r_use_pc;
  logic            r_use_imm;

  // Handshake and bypass wires
  logic            w_capture;
  bypass_t         w_cap_bp_rs1;
  bypass_t         w_cap_bp_rs2;
  bypass_t         w_hold_bp_rs1;
  bypass_t         w_hold_bp_rs2;
  logic [XLEN-1:0] w_fwd_rs1;
  logic [XLEN-1:0] w_fwd_rs2;
  logic [XLEN-1:0] w_cap_a;
  logic [XLEN-1:0] w_cap_b;

  // A flush redirects fetch, so nothing is accepted while it is asserted.
  assign id_ready  = !flush && (!r_valid || ex_ready);
  assign w_capture = id_valid && id_ready;

  // Bypass lookups for the incoming instruction and for the held one.
  assign w_cap_bp_rs1  = bypass_lookup(id_rs1_addr, mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
                                       wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
  assign w_cap_bp_rs2  = bypass_lookup(id_rs2_addr, mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
                                       wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
  assign w_hold_bp_rs1 = bypass_lookup(r_rs1_addr, mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
                                       wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
  assign w_hold_bp_rs2 = bypass_lookup(r_rs2_addr, mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
                                       wb_fwd_valid, wb_fwd_rd, wb_fwd_data);

  // Resolve the forwarded source values and the operands of the incoming instruction.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path can leave one
    // unassigned and infer a latch.
    w_fwd_rs1 = id_rs1_data;
    w_fwd_rs2 = id_rs2_data;
    if (id_rs1_addr == 5'd0)   w_fwd_rs1 = '0;
    else if (w_cap_bp_rs1.hit) w_fwd_rs1 = w_cap_bp_rs1.data;
    if (id_rs2_addr == 5'd0)   w_fwd_rs2 = '0;
    else if (w_cap_bp_rs2.hit) w_fwd_rs2 = w_cap_bp_rs2.data;
    w_cap_a = id_use_pc  ? id_pc  : w_fwd_rs1;
    w_cap_b = id_use_imm ? id_imm : w_fwd_rs2;
  end

  // Stage register: flush > capture > drain > hold-with-snoop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are reset as well as the valid bit, so the outputs
      // are deterministic straight out of reset. Nothing here is a memory array.
      r_valid      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_alu_op     <= 4'b0000;
      r_store_data <= '0;
      r_rd_addr    <= 5'd0;
      r_reg_write  <= 1'b0;
      r_pc         <= '0;
      r_rs1_addr   <= 5'd0;
      r_rs2_addr   <= 5'd0;
      r_use_pc     <= 1'b0;
      r_use_imm    <= 1'b0;
    end else if (flush) begin
      // NOTE: non-blocking assignments throughout, so every register samples the values
      // from before this edge and the order of the statements cannot matter.
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid      <= 1'b1;
      r_a          <= w_cap_a;
      r_b          <= w_cap_b;
      r_alu_op     <= id_alu_op;
      r_store_data <= w_fwd_rs2;
      r_rd_addr    <= id_rd_addr;
      r_reg_write  <= id_reg_write;
      r_pc         <= id_pc;
      r_rs1_addr   <= id_rs1_addr;
      r_rs2_addr   <= id_rs2_addr;
      r_use_pc     <= id_use_pc;
      r_use_imm    <= id_use_imm;
    end else if (ex_ready) begin
      // Drained with nothing behind it; the data fields keep their last values.
      r_valid <= 1'b0;
    end else if (r_valid) begin
      // Stalled: pick up results that retire while this entry waits.
      if (!r_use_pc && w_hold_bp_rs1.hit)  r_a <= w_hold_bp_rs1.data;
      if (!r_use_imm && w_hold_bp_rs2.hit) r_b <= w_hold_bp_rs2.data;
      if (w_hold_bp_rs2.hit)               r_store_data <= w_hold_bp_rs2.data;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_a          = r_a;
  assign ex_b          = r_b;
  assign ex_alu_op     = r_alu_op;
  assign ex_store_data = r_store_data;
  assign ex_rd_addr    = r_rd_addr;
  assign ex_reg_write  = r_reg_write;
  assign ex_pc         = r_pc;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage. Inputs are driven 1 ns after a rising edge and
// outputs are sampled at that same point, well away from the next active edge.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [3:0]  id_alu_op;
  logic        id_use_pc, id_use_imm, id_reg_write;
  logic        mem_fwd_valid;
  logic [4:0]  mem_fwd_rd;
  logic [31:0] mem_fwd_data;
  logic        wb_fwd_valid;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_a, ex_b, ex_store_data, ex_pc;
  logic [3:0]  ex_alu_op;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_use_pc(id_use_pc), .id_use_imm(id_use_imm),
    .id_reg_write(id_reg_write),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_a(ex_a), .ex_b(ex_b),
    .ex_alu_op(ex_alu_op), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_pc(ex_pc)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---- reset state ----
    rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; id_pc = '0;
    id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
    id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_alu_op = '0;
    id_use_pc = 1'b0; id_use_imm = 1'b0; id_reg_write = 1'b0;
    mem_fwd_valid = 1'b0; mem_fwd_rd = '0; mem_fwd_data = '0;
    wb_fwd_valid = 1'b0; wb_fwd_rd = '0; wb_fwd_data = '0;
    ex_ready = 1'b1;
    #2;
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_a", ex_a, 32'd0);
    check("rst_b", ex_b, 32'd0);
    check("rst_store", ex_store_data, 32'd0);
    check("rst_pc", ex_pc, 32'd0);
    check("rst_op", 32'(ex_alu_op), 32'd0);
    check("rst_rd", 32'(ex_rd_addr), 32'd0);
    check("rst_regwr", 32'(ex_reg_write), 32'd0);
    check("rst_id_ready", 32'(id_ready), 32'd1);
    tick();
    rst_n = 1'b1;

    // ---- basic pass ----
    id_valid = 1'b1; id_pc = 32'h100;
    id_rs1_addr = 5'd3; id_rs1_data = 32'd5;
    id_rs2_addr = 5'd4; id_rs2_data = 32'd7;
    id_rd_addr = 5'd1; id_reg_write = 1'b1; id_alu_op = 4'b0000;
    tick();
    check("basic_valid", 32'(ex_valid), 32'd1);
    check("basic_a", ex_a, 32'd5);
    check("basic_b", ex_b, 32'd7);
    check("basic_op", 32'(ex_alu_op), 32'd0);
    check("basic_store", ex_store_data, 32'd7);
    check("basic_rd", 32'(ex_rd_addr), 32'd1);
    check("basic_regwr", 32'(ex_reg_write), 32'd1);
    check("basic_pc", ex_pc, 32'h100);

    // ---- bypass priority: MEM over WB over regfile ----
    id_pc = 32'h104; id_alu_op = 4'b0010;
    id_rs1_addr = 5'd5; id_rs1_data = 32'h33;
    id_rs2_addr = 5'd6; id_rs2_data = 32'h44;
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'h11;
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd5; wb_fwd_data = 32'h22;
    tick();
    check("prio_mem_a", ex_a, 32'h11);
    check("prio_mem_b", ex_b, 32'h44);
    check("prio_op", 32'(ex_alu_op), 32'd2);
    mem_fwd_valid = 1'b0;
    tick();
    check("prio_wb_a", ex_a, 32'h22);

    // ---- x0 guard on both sources ----
    id_rs1_addr = 5'd0; id_rs1_data = 32'h55;
    id_rs2_addr = 5'd0; id_rs2_data = 32'h9;
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hFFFF_FFFF;
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd0; wb_fwd_data = 32'h77;
    tick();
    check("x0_a", ex_a, 32'd0);
    check("x0_b", ex_b, 32'd0);
    check("x0_store", ex_store_data, 32'd0);
    mem_fwd_valid = 1'b0; wb_fwd_valid = 1'b0;

    // ---- PC and immediate operand selection ----
    id_pc = 32'h200; id_use_pc = 1'b1; id_use_imm = 1'b1; id_imm = 32'hFFFF_FFF0;
    id_rs1_addr = 5'd3; id_rs1_data = 32'd5;
    id_rs2_addr = 5'd4; id_rs2_data = 32'd7; id_alu_op = 4'b0110;
    tick();
    check("sel_a_pc", ex_a, 32'h200);
    check("sel_b_imm", ex_b, 32'hFFFF_FFF0);
    check("sel_store_rs2", ex_store_data, 32'd7);
    check("sel_op", 32'(ex_alu_op), 32'd6);

    // ---- stall snoop ----
    id_pc = 32'h300; id_use_pc = 1'b0; id_use_imm = 1'b1; id_imm = 32'h10;
    id_rs1_addr = 5'd7; id_rs1_data = 32'd1;
    id_rs2_addr = 5'd8; id_rs2_data = 32'd2; id_alu_op = 4'b0001; id_rd_addr = 5'd9;
    tick();
    check("stall_cap_a", ex_a, 32'd1);
    check("stall_cap_b", ex_b, 32'h10);
    check("stall_cap_store", ex_store_data, 32'd2);
    // A different instruction is offered while the stage is stalled; it must not load.
    ex_ready = 1'b0; id_pc = 32'h400; id_rs1_data = 32'h99;
    #1;
    check("stall_c1_id_ready", 32'(id_ready), 32'd0);
    tick();
    check("stall_c1_a", ex_a, 32'd1);
    check("stall_c2_id_ready", 32'(id_ready), 32'd0);
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd7; wb_fwd_data = 32'hAB;
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd8; mem_fwd_data = 32'hCD;
    tick();
    check("stall_snoop_a", ex_a, 32'hAB);
    check("stall_imm_kept_b", ex_b, 32'h10);
    check("stall_snoop_store", ex_store_data, 32'hCD);
    check("stall_c3_id_ready", 32'(id_ready), 32'd0);
    mem_fwd_valid = 1'b0; wb_fwd_valid = 1'b0;
    tick();
    check("stall_hold_a", ex_a, 32'hAB);
    check("stall_hold_store", ex_store_data, 32'hCD);
    check("stall_hold_pc", ex_pc, 32'h300);
    check("stall_hold_valid", 32'(ex_valid), 32'd1);

    // ---- flush overrides hold and capture ----
    flush = 1'b1;
    #1;
    check("flush_id_ready", 32'(id_ready), 32'd0);
    tick();
    check("flush_valid", 32'(ex_valid), 32'd0);
    flush = 1'b0; ex_ready = 1'b1;

    // ---- four back-to-back instructions ----
    id_use_imm = 1'b0; id_rs2_addr = 5'd0; id_rs1_addr = 5'd9;
    for (int k = 1; k <= 4; k++) begin
      id_rs1_data = 32'(k * 16); id_pc = 32'(k * 4);
      tick();
      check($sformatf("stream%0d_valid", k), 32'(ex_valid), 32'd1);
      check($sformatf("stream%0d_a", k), ex_a, 32'(k * 16));
    end
    id_valid = 1'b0;
    tick();
    check("drain_valid", 32'(ex_valid), 32'd0);
    check("drain_a_kept", ex_a, 32'h40);

    // ---- async reset in the middle of a stall ----
    id_valid = 1'b1; id_rs1_data = 32'h5A;
    tick();
    check("pre_rst_a", ex_a, 32'h5A);
    id_valid = 1'b0; ex_ready = 1'b0;
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(ex_valid), 32'd0);
    check("async_rst_a", ex_a, 32'd0);
    check("async_rst_regwr", 32'(ex_reg_write), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_id_ready", 32'(id_ready), 32'd1);
    check("post_rst_valid", 32'(ex_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
